duty_ramp: RTL and testbench



---
 rtl/duty_ramp.sv | 118 +++++++++++
 tb/tb_duty_ramp.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/duty_ramp.sv
// Slews the PWM duty register toward a software target by at most one step per PWM period.
// Latency: duty_load strobes in the cycle after the rollover cycle that triggers a step.
// Backpressure: none; target/step writes are accepted every cycle in any state.
module duty_ramp #(
  parameter int WIDTH      = 16,
  parameter int MSB        = WIDTH - 1,
  parameter int START      = 65535,
  parameter int STEP_RESET = 1
) (
  input  logic             sysclk,
  input  logic             sysreset,
  input  logic [15:0]      counter_value,
  input  logic [WIDTH-1:0] data_in,
  input  logic             target_load,
  input  logic             step_load,
  output logic [15:0]      target,
  output logic [15:0]      step,
  output logic [WIDTH-1:0] duty_out,
  output logic             duty_load,
  output logic             busy,
  output logic             done
);

  localparam logic [MSB:0] START_W      = START[MSB:0];
  localparam logic [MSB:0] STEP_RESET_W = STEP_RESET[MSB:0];

  typedef enum logic [1:0] {IDLE, WAIT, LOAD} state_t;

  state_t         state_q, state_d;
  logic [MSB:0]   cur, target_q, step_q;
  logic [MSB:0]   nxt;
  logic [MSB:0]   dif;
  logic [WIDTH:0] sum;
  logic           match, roll_prev, roll, cur_en;

  // Rollover is the first cycle the counter shows its reload value.
  assign match = (counter_value[MSB:0] == START_W);
  assign roll  = match && !roll_prev;

  assign duty_out = cur;
  assign sum      = {1'b0, cur} + {1'b0, step_q};
  assign dif      = cur - step_q;

  // Zero-extend register readback to the 16-bit software view.
  always_comb begin
    target          = '0;
    step            = '0;
    target[MSB:0]   = target_q;
    step[MSB:0]     = step_q;
  end

  // Next duty: one step toward target, clamped at target, never wrapping.
  always_comb begin
    nxt = cur;
    if (step_q == '0) begin
      nxt = target_q;
    end else if (cur < target_q) begin
      nxt = (sum > {1'b0, target_q}) ? target_q : sum[MSB:0];
    end else if (cur > target_q) begin
      nxt = ((step_q > cur) || (dif < target_q)) ? target_q : dif;
    end
  end

  // Sequencer next-state and strobes.
  always_comb begin
    state_d   = state_q;
    cur_en    = 1'b0;
    busy      = 1'b0;
    duty_load = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cur != target_q) state_d = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (roll) begin
          if (cur == target_q) begin
            // Target was rewritten back to the current duty: nothing to load.
            state_d = IDLE;
          end else begin
            cur_en  = 1'b1;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        duty_load = 1'b1;
        busy      = (cur != target_q);
        if (cur == target_q) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, shadow duty and software registers.
  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      state_q   <= IDLE;
      cur       <= '0;
      target_q  <= '0;
      step_q    <= STEP_RESET_W;
      roll_prev <= 1'b0;
    end else begin
      state_q   <= state_d;
      roll_prev <= match;
      if (cur_en)      cur      <= nxt;
      if (target_load) target_q <= data_in;
      if (step_load)   step_q   <= data_in;
    end
  end

endmodule

// File: tb/tb_duty_ramp.sv
// Randomized bench for duty_ramp: per-cycle comparison against a behavioural ramp model.
// Writes land mid-period, well clear of rollovers, so each rollover is a step decision.
// Each scenario task also checks its observed load sequence against literal values.
module tb_duty_ramp;
  localparam int START = 65535;

  logic        sysclk = 1'b0;
  logic        sysreset;
  logic [15:0] counter_value;
  logic [15:0] data_in;
  logic        target_load, step_load;
  logic [15:0] target, step, duty_out;
  logic        duty_load, busy, done;

  always #5 sysclk = ~sysclk;

  duty_ramp #(.WIDTH(16), .MSB(15), .START(START), .STEP_RESET(1)) dut (
    .sysclk(sysclk), .sysreset(sysreset), .counter_value(counter_value),
    .data_in(data_in), .target_load(target_load), .step_load(step_load),
    .target(target), .step(step), .duty_out(duty_out),
    .duty_load(duty_load), .busy(busy), .done(done)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: duty value, registers, and a load scheduled for the next cycle.
  int cur_m, tgt_m, stp_m;
  bit prev_match_m, pend_load, pend_done;
  int loads[$];
  int dones;

  function automatic int next_duty(int c, int t, int s);
    if (s == 0) return t;
    if (c < t) return (c + s > t) ? t : c + s;
    if (c > t) return (c - s < t) ? t : c - s;
    return c;
  endfunction

  task automatic model_reset();
    cur_m = 0; tgt_m = 0; stp_m = 1;
    prev_match_m = 0; pend_load = 0; pend_done = 0;
  endtask

  task automatic run_cycle(input int cnt, input bit rst, input bit tl, input bit sl,
                           input int din, input bit chk_busy);
    bit roll;
    @(posedge sysclk); #1;
    counter_value = 16'(cnt); sysreset = rst;
    target_load = tl; step_load = sl; data_in = 16'(din);
    @(negedge sysclk);
    checks++;
    if (duty_load !== pend_load) begin
      errors++; $display("FAIL duty_load t=%0t got %b want %b", $time, duty_load, pend_load);
    end
    checks++;
    if (done !== (pend_load && pend_done)) begin
      errors++; $display("FAIL done t=%0t got %b want %b", $time, done, pend_load && pend_done);
    end
    checks++;
    if (duty_out !== 16'(cur_m)) begin
      errors++; $display("FAIL duty_out t=%0t got %0d want %0d", $time, duty_out, cur_m);
    end
    checks++;
    if (target !== 16'(tgt_m)) begin
      errors++; $display("FAIL target t=%0t got %0d want %0d", $time, target, tgt_m);
    end
    checks++;
    if (step !== 16'(stp_m)) begin
      errors++; $display("FAIL step t=%0t got %0d want %0d", $time, step, stp_m);
    end
    if (chk_busy) begin
      checks++;
      if (busy !== (cur_m != tgt_m)) begin
        errors++; $display("FAIL busy t=%0t got %b want %b", $time, busy, cur_m != tgt_m);
      end
    end
    if (duty_load === 1'b1) loads.push_back(int'(duty_out));
    if (done === 1'b1) dones++;
    if (rst) begin
      model_reset();
    end else begin
      roll = (cnt == START) && !prev_match_m;
      prev_match_m = (cnt == START);
      pend_load = 0; pend_done = 0;
      if (roll && cur_m != tgt_m) begin
        cur_m = next_duty(cur_m, tgt_m, stp_m);
        pend_load = 1;
        pend_done = (cur_m == tgt_m);
      end
      if (tl) tgt_m = din;
      if (sl) stp_m = din;
    end
  endtask

  // One PWM period: counter at START for h cycles, then other values. Optional step write
  // at cycle 3, target writes at cycles 4 and 6, optional reset at cycle rst_at.
  task automatic run_period(input bit sl, input int sv, input bit tl1, input int tv1,
                            input bit tl2, input int tv2, input int rst_at);
    int p, h, cnt, din;
    p = $urandom_range(9, 14);
    h = $urandom_range(1, 3);
    for (int k = 0; k < p; k++) begin
      cnt = (k < h) ? START : int'($urandom_range(0, START - 1));
      din = (k == 3) ? sv : (k == 4) ? tv1 : (k == 6) ? tv2 : int'($urandom_range(0, 65535));
      run_cycle(cnt, k == rst_at, (tl1 && k == 4) || (tl2 && k == 6), sl && k == 3, din, k == 2);
    end
  endtask

  task automatic idle_periods(input int n);
    for (int i = 0; i < n; i++) run_period(0, 0, 0, 0, 0, 0, -1);
  endtask

  task automatic test_reset();
    sysreset = 1; counter_value = 16'(START); data_in = '0; target_load = 0; step_load = 0;
    repeat (2) @(posedge sysclk);
    model_reset();
    loads.delete(); dones = 0;
    for (int i = 0; i < 20; i++) run_cycle(START, 0, 0, 0, int'($urandom_range(0, 65535)), 1);
    for (int i = 0; i < 3; i++) run_cycle(int'($urandom_range(0, START - 1)), 0, 0, 0, 0, 1);
    checks++;
    if (loads.size() != 0 || dones != 0) begin
      errors++; $display("FAIL reset_idle loads=%0d dones=%0d want 0 0", loads.size(), dones);
    end
  endtask

  task automatic test_ramp_up();
    int exp_l[$];
    exp_l = '{100, 200, 300};
    loads.delete(); dones = 0;
    run_period(1, 100, 1, 300, 0, 0, -1);
    idle_periods(4);
    checks++;
    if (loads != exp_l || dones != 1 || busy !== 1'b0) begin
      errors++; $display("FAIL ramp_up loads=%p dones=%0d busy=%b want %p 1 0", loads, dones, busy, exp_l);
    end
  endtask

  task automatic test_jump();
    int exp_l[$];
    exp_l = '{50};
    loads.delete(); dones = 0;
    run_period(1, 0, 1, 50, 0, 0, -1);
    idle_periods(2);
    checks++;
    if (loads != exp_l || dones != 1) begin
      errors++; $display("FAIL jump_step0 loads=%p dones=%0d want %p 1", loads, dones, exp_l);
    end
    run_period(0, 0, 1, 39500, 0, 0, -1);
    idle_periods(1);
    exp_l = '{40000};
    loads.delete(); dones = 0;
    run_period(1, 1000, 1, 40000, 0, 0, -1);
    idle_periods(2);
    checks++;
    if (loads != exp_l || dones != 1) begin
      errors++; $display("FAIL clamp_up loads=%p dones=%0d want %p 1", loads, dones, exp_l);
    end
  endtask

  task automatic test_ramp_down();
    int exp_l[$];
    exp_l = '{30, 0};
    run_period(1, 0, 1, 100, 0, 0, -1);
    idle_periods(1);
    loads.delete(); dones = 0;
    run_period(1, 70, 1, 0, 0, 0, -1);
    idle_periods(3);
    checks++;
    if (loads != exp_l || dones != 1) begin
      errors++; $display("FAIL ramp_down loads=%p dones=%0d want %p 1", loads, dones, exp_l);
    end
  endtask

  task automatic test_revert();
    run_period(1, 0, 1, 200, 0, 0, -1);
    idle_periods(1);
    loads.delete(); dones = 0;
    run_period(1, 50, 1, 500, 1, 200, -1);
    idle_periods(2);
    checks++;
    if (loads.size() != 0 || dones != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL revert loads=%p dones=%0d busy=%b want none 0 0", loads, dones, busy);
    end
  endtask

  task automatic test_reset_in_load();
    int exp_l[$];
    exp_l = '{250};
    loads.delete(); dones = 0;
    run_period(1, 50, 1, 400, 0, 0, -1);
    run_period(0, 0, 0, 0, 0, 0, 1);
    idle_periods(2);
    checks++;
    if (loads != exp_l || dones != 0 || target !== 16'd0 || step !== 16'd1 || duty_out !== 16'd0) begin
      errors++; $display("FAIL reset_in_load loads=%p dones=%0d tgt=%0d step=%0d duty=%0d want %p 0 0 1 0",
                         loads, dones, target, step, duty_out, exp_l);
    end
  endtask

  task automatic test_random();
    int sv, tv;
    for (int i = 0; i < 25; i++) begin
      sv = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 20000));
      tv = ($urandom_range(0, 5) == 0) ? START : int'($urandom_range(0, 65535));
      run_period($urandom_range(0, 1) == 1, sv, $urandom_range(0, 2) != 0, tv,
                 $urandom_range(0, 5) == 0, int'($urandom_range(0, 65535)), -1);
    end
    // Both strobes together: each register takes the shared data word.
    run_cycle(int'($urandom_range(0, START - 1)), 0, 1, 1, 777, 0);
    run_cycle(int'($urandom_range(0, START - 1)), 0, 0, 0, 0, 0);
    checks++;
    if (target !== 16'd777 || step !== 16'd777) begin
      errors++; $display("FAIL dual_load tgt=%0d step=%0d want 777 777", target, step);
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_jump();
    test_ramp_down();
    test_revert();
    test_reset_in_load();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
